// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the multi-port register file: default geometry and
// the byte-strobe width helper used by the RTL and the testbench.
package reg_file_mp_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_NUM_RD     = 2;

  // Number of byte strobes for an entry of the given width.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One asynchronous read port of reg_file_mp.
// Ports:
//   raddr          - read address
//   mem            - full storage array (byte-organised entries)
//   we0/1          - effective write enables (already gated by reset/zero entry)
//   waddr0/1       - write addresses
//   strb0/1        - effective strobes (port 0 already masked by port 1 priority)
//   wdata0/1       - write data
//   rdata          - read data for this port (combinational)
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 0,
  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH),
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]           raddr,
  input  logic [STRB_WIDTH-1:0][7:0]      mem [DEPTH],
  input  logic                            we0,
  input  logic [ADDR_WIDTH-1:0]           waddr0,
  input  logic [STRB_WIDTH-1:0]           strb0,
  input  logic [STRB_WIDTH-1:0][7:0]      wdata0,
  input  logic                            we1,
  input  logic [ADDR_WIDTH-1:0]           waddr1,
  input  logic [STRB_WIDTH-1:0]           strb1,
  input  logic [STRB_WIDTH-1:0][7:0]      wdata1,
  output logic [STRB_WIDTH-1:0][7:0]      rdata
);

  logic hit0_c;
  logic hit1_c;

  assign hit0_c = (BYPASS != 0) && we0 && (waddr0 == raddr);
  assign hit1_c = (BYPASS != 0) && we1 && (waddr1 == raddr);

  // Storage value with bypassed bytes overlaid, port 1 taking precedence.
  always_comb begin
    rdata = mem[raddr];
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (hit1_c && strb1[b]) begin
        rdata[b] = wdata1[b];
      end else if (hit0_c && strb0[b]) begin
        rdata[b] = wdata0[b];
      end
    end
    if ((ZERO_REG != 0) && (raddr == '0)) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: NUM_RD asynchronous read ports, two
// byte-strobed write ports (port 1 wins per byte on address conflicts),
// optional hardwired-zero entry 0 and optional write-to-read bypass.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   wen0/waddr0/wstrb0/wdata0    - write port 0
//   wen1/waddr1/wstrb1/wdata1    - write port 1 (higher priority)
//   raddr                        - packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata                        - packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_RD     = DEF_NUM_RD,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 0,
  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH),
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen0,
  input  logic [ADDR_WIDTH-1:0]            waddr0,
  input  logic [STRB_WIDTH-1:0]            wstrb0,
  input  logic [DATA_WIDTH-1:0]            wdata0,
  input  logic                             wen1,
  input  logic [ADDR_WIDTH-1:0]            waddr1,
  input  logic [STRB_WIDTH-1:0]            wstrb1,
  input  logic [DATA_WIDTH-1:0]            wdata1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rdata
);

  logic [STRB_WIDTH-1:0][7:0] mem_q [DEPTH];
  logic [STRB_WIDTH-1:0][7:0] wdata0_b;
  logic [STRB_WIDTH-1:0][7:0] wdata1_b;
  logic                       we0_c;
  logic                       we1_c;
  logic [STRB_WIDTH-1:0]      strb0_c;

  assign wdata0_b = wdata0;
  assign wdata1_b = wdata1;

  // Effective enables: reset discards writes, zero entry swallows them.
  assign we0_c = wen0 && !rst && !((ZERO_REG != 0) && (waddr0 == '0));
  assign we1_c = wen1 && !rst && !((ZERO_REG != 0) && (waddr1 == '0));

  // Port 0 loses any byte port 1 also strobes at the same address.
  assign strb0_c = (we1_c && (waddr0 == waddr1)) ? (wstrb0 & ~wstrb1) : wstrb0;

  // Storage update; the two ports never write the same byte after masking.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (we0_c && strb0_c[b]) begin
          mem_q[waddr0][b] <= wdata0_b[b];
        end
        if (we1_c && wstrb1[b]) begin
          mem_q[waddr1][b] <= wdata1_b[b];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_rd (
      .raddr  (raddr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem    (mem_q),
      .we0    (we0_c),
      .waddr0 (waddr0),
      .strb0  (strb0_c),
      .wdata0 (wdata0_b),
      .we1    (we1_c),
      .waddr1 (waddr1),
      .strb1  (wstrb1),
      .wdata1 (wdata1_b),
      .rdata  (rdata[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one instance without bypass and one with,
// both with the zero entry enabled and driven by identical stimulus.
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  localparam int unsigned DW = DEF_DATA_WIDTH;
  localparam int unsigned AW = DEF_ADDR_WIDTH;
  localparam int unsigned SW = strb_width(DW);

  logic          clk = 1'b0;
  logic          rst;
  logic          wen0, wen1;
  logic [AW-1:0] waddr0, waddr1;
  logic [SW-1:0] wstrb0, wstrb1;
  logic [DW-1:0] wdata0, wdata1;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rd_nb;
  logic [2*DW-1:0] rd_by;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wstrb0(wstrb0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wstrb1(wstrb1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rd_nb)
  );

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_by (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wstrb0(wstrb0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wstrb1(wstrb1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rd_by)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic idle();
    wen0 = 1'b0; wen1 = 1'b0;
    wstrb0 = '0; wstrb1 = '0;
  endtask

  initial begin
    rst = 1'b1;
    wen0 = 1'b0; waddr0 = '0; wstrb0 = '0; wdata0 = '0;
    wen1 = 1'b0; waddr1 = '0; wstrb1 = '0; wdata1 = '0;
    raddr = '0;
    tick();
    tick();
    rst = 1'b0;

    // All entries read zero after reset.
    for (int a = 0; a < 32; a++) begin
      set_rd(AW'(a), AW'(31 - a));
      #1;
      check($sformatf("reset_nb_p0_a%0d", a), rd_nb[DW-1:0], 32'h0);
      check($sformatf("reset_nb_p1_a%0d", a), rd_nb[2*DW-1:DW], 32'h0);
      check($sformatf("reset_by_p0_a%0d", a), rd_by[DW-1:0], 32'h0);
    end

    // Full write to address 5: visible next cycle without bypass, same cycle with.
    wen0 = 1'b1; waddr0 = 5; wstrb0 = 4'hF; wdata0 = 32'hDEADBEEF;
    set_rd(5, 5);
    #1;
    check("wr5_same_nb", rd_nb[DW-1:0], 32'h0);
    check("wr5_same_by", rd_by[DW-1:0], 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("wr5_next_nb", rd_nb[DW-1:0], 32'hDEADBEEF);
    check("wr5_next_nb_p1", rd_nb[2*DW-1:DW], 32'hDEADBEEF);

    // Same-address conflict merge at address 7.
    wen0 = 1'b1; waddr0 = 7; wstrb0 = 4'hF; wdata0 = 32'h11223344;
    tick();
    wen0 = 1'b1; waddr0 = 7; wstrb0 = 4'h3; wdata0 = 32'hAAAAAAAA;
    wen1 = 1'b1; waddr1 = 7; wstrb1 = 4'h6; wdata1 = 32'hBBBBBBBB;
    set_rd(7, 5);
    #1;
    check("merge7_same_nb", rd_nb[DW-1:0], 32'h11223344);
    check("merge7_same_by", rd_by[DW-1:0], 32'h11BBBBAA);
    check("merge7_same_by_other", rd_by[2*DW-1:DW], 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("merge7_next_nb", rd_nb[DW-1:0], 32'h11BBBBAA);
    check("merge7_next_by", rd_by[DW-1:0], 32'h11BBBBAA);

    // Zero entry ignores writes from both ports, including under bypass.
    wen0 = 1'b1; waddr0 = 0; wstrb0 = 4'hF; wdata0 = 32'hFFFFFFFF;
    wen1 = 1'b1; waddr1 = 0; wstrb1 = 4'hF; wdata1 = 32'hFFFFFFFF;
    set_rd(0, 0);
    #1;
    check("zero_same_nb", rd_nb[DW-1:0], 32'h0);
    check("zero_same_by", rd_by[DW-1:0], 32'h0);
    check("zero_same_by_p1", rd_by[2*DW-1:DW], 32'h0);
    tick();
    idle();
    #1;
    check("zero_next_nb", rd_nb[DW-1:0], 32'h0);
    check("zero_next_by", rd_by[DW-1:0], 32'h0);

    // Partial bypass at address 3 from port 1 only.
    wen0 = 1'b1; waddr0 = 3; wstrb0 = 4'hF; wdata0 = 32'h01020304;
    tick();
    idle();
    wen1 = 1'b1; waddr1 = 3; wstrb1 = 4'hC; wdata1 = 32'hCAFEF00D;
    set_rd(3, 3);
    #1;
    check("byp3_same_by_p0", rd_by[DW-1:0], 32'hCAFE0304);
    check("byp3_same_by_p1", rd_by[2*DW-1:DW], 32'hCAFE0304);
    check("byp3_same_nb", rd_nb[DW-1:0], 32'h01020304);
    tick();
    idle();
    #1;
    check("byp3_next_nb", rd_nb[DW-1:0], 32'hCAFE0304);
    check("byp3_next_by", rd_by[2*DW-1:DW], 32'hCAFE0304);

    // Independent addresses commit together; zero strobe is a no-op.
    wen0 = 1'b1; waddr0 = 10; wstrb0 = 4'hF; wdata0 = 32'h0000AAAA;
    wen1 = 1'b1; waddr1 = 11; wstrb1 = 4'hF; wdata1 = 32'h00005555;
    tick();
    idle();
    wen0 = 1'b1; waddr0 = 10; wstrb0 = 4'h0; wdata0 = 32'hFFFFFFFF;
    set_rd(10, 11);
    #1;
    check("nostrb_same_by", rd_by[DW-1:0], 32'h0000AAAA);
    tick();
    idle();
    #1;
    check("dual10_nb", rd_nb[DW-1:0], 32'h0000AAAA);
    check("dual11_nb", rd_nb[2*DW-1:DW], 32'h00005555);

    // Write during reset is lost; bypass is suppressed; pre-reset data visible.
    rst = 1'b1;
    wen0 = 1'b1; waddr0 = 9; wstrb0 = 4'hF; wdata0 = 32'h12345678;
    set_rd(9, 5);
    #1;
    check("rst_byp_off", rd_by[DW-1:0], 32'h0);
    check("rst_old_data_by", rd_by[2*DW-1:DW], 32'hDEADBEEF);
    check("rst_old_data_nb", rd_nb[2*DW-1:DW], 32'hDEADBEEF);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rst_lost9_nb", rd_nb[DW-1:0], 32'h0);
    check("rst_clear5_nb", rd_nb[2*DW-1:DW], 32'h0);
    check("rst_clear5_by", rd_by[2*DW-1:DW], 32'h0);
    wen0 = 1'b1; waddr0 = 9; wstrb0 = 4'hF; wdata0 = 32'h12345678;
    tick();
    idle();
    #1;
    check("post_rst_wr9_nb", rd_nb[DW-1:0], 32'h12345678);
    check("post_rst_wr9_by", rd_by[DW-1:0], 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
